sequence_product_cache: RTL and testbench

- Parametrised successor to the sequence multiplier.
- Accepts gates of a candidate sequence from the Sequence Generator, highest index first, and keeps a per-level cache of 2x2 complex partial products, where P[i] = P[i+1] * G[i], or P[i] = G[i] when the gate is first.
- Adds per-level valid tags, invalidation of dependent levels, bounds and dependency error checking, a flush command and a hit counter.
- Feeds the Solution Checker and Duplicate Checker through result_mtx / result_valid.

---
 rtl/sequence_product_cache_pkg.sv | 18 +
 rtl/sequence_product_cache_if.sv | 43 ++++
 rtl/sequence_product_cache_bank.sv | 78 +++++++
 rtl/sequence_product_cache.sv | 209 ++++++++++++++++++++
 tb/tb_sequence_product_cache.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sequence_product_cache_pkg.sv
// Shared types for the sequence product cache: complex 2x2 matrix layout,
// gate-id width and the controller state encoding.
package sequence_product_cache_pkg;

    localparam int NUMERIC_BITS = 19;
    localparam int GATE_BITS    = 5;

    // Indexed [row][col][re/im]; each element is a signed fixed-point value.
    typedef logic [0:1][0:1][0:1][NUMERIC_BITS-1:0] cmat_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        MUL,
        WRITE
    } state_e;

endpackage

// File: rtl/sequence_product_cache_if.sv
// Request, result, gate-table and multiplier signals of the sequence product cache.
interface sequence_product_cache_if
    import sequence_product_cache_pkg::*;
#(
    parameter int IDX_BITS     = 4,
    parameter int HIT_CNT_BITS = 16
);

    logic                    flush;
    logic                    seq_valid;
    logic                    seq_ready;
    logic [IDX_BITS-1:0]     seq_index;
    logic [GATE_BITS-1:0]    seq_gate;
    logic                    seq_first;
    cmat_t                   result_mtx;
    logic                    result_valid;
    logic                    err;
    logic [HIT_CNT_BITS-1:0] hit_count;
    logic [GATE_BITS-1:0]    gt_gate;
    logic                    gt_req;
    logic                    gt_done;
    cmat_t                   gt_mtx;
    cmat_t                   mul_a;
    cmat_t                   mul_b;
    logic                    mul_start;
    logic                    mul_done;
    cmat_t                   mul_result;

    modport slave (
        input  flush, seq_valid, seq_index, seq_gate, seq_first,
        input  gt_done, gt_mtx, mul_done, mul_result,
        output seq_ready, result_mtx, result_valid, err, hit_count,
        output gt_gate, gt_req, mul_a, mul_b, mul_start
    );

    modport master (
        output flush, seq_valid, seq_index, seq_gate, seq_first,
        output gt_done, gt_mtx, mul_done, mul_result,
        input  seq_ready, result_mtx, result_valid, err, hit_count,
        input  gt_gate, gt_req, mul_a, mul_b, mul_start
    );

endinterface

// File: rtl/sequence_product_cache_bank.sv
// Per-level storage of partial products, their gate/first tags and valid bits,
// with a tag write that also invalidates every level at or below it.
module sequence_product_cache_bank
    import sequence_product_cache_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int IDX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic [IDX_BITS-1:0]  lkIdx_i,
    input  logic                 tagWe_i,
    input  logic [GATE_BITS-1:0] tagGate_i,
    input  logic                 tagFirst_i,
    input  logic                 wrEn_i,
    input  logic [IDX_BITS-1:0]  wrIdx_i,
    input  cmat_t                wrMtx_i,
    input  logic [IDX_BITS-1:0]  rdIdx_i,
    output cmat_t                rdMtx_o,
    output cmat_t                lvl0Mtx_o,
    output logic                 lkVld_o,
    output logic [GATE_BITS-1:0] lkGate_o,
    output logic                 lkFirst_o,
    output logic [DEPTH-1:0]     vld_o
);

    cmat_t                mtx_q     [DEPTH];
    logic [GATE_BITS-1:0] tagGate_q [DEPTH];
    logic [DEPTH-1:0]     tagFirst_q;
    logic [DEPTH-1:0]     vld_q;

    // A completed write wins over the invalidate; both never target one level in one cycle.
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (reset || flush_i) begin
                vld_q[j] <= 1'b0;
            end else if (wrEn_i && wrIdx_i == IDX_BITS'(j)) begin
                vld_q[j] <= 1'b1;
            end else if (tagWe_i && IDX_BITS'(j) <= lkIdx_i) begin
                vld_q[j] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (tagWe_i && lkIdx_i == IDX_BITS'(j)) begin
                tagGate_q[j]  <= tagGate_i;
                tagFirst_q[j] <= tagFirst_i;
            end
            if (wrEn_i && wrIdx_i == IDX_BITS'(j)) begin
                mtx_q[j] <= wrMtx_i;
            end
        end
    end

    always_comb begin
        rdMtx_o   = '0;
        lkVld_o   = 1'b0;
        lkGate_o  = '0;
        lkFirst_o = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (rdIdx_i == IDX_BITS'(j)) begin
                rdMtx_o = mtx_q[j];
            end
            if (lkIdx_i == IDX_BITS'(j)) begin
                lkVld_o   = vld_q[j];
                lkGate_o  = tagGate_q[j];
                lkFirst_o = tagFirst_q[j];
            end
        end
    end

    assign lvl0Mtx_o = mtx_q[0];
    assign vld_o     = vld_q;

endmodule

// File: rtl/sequence_product_cache.sv
// Caches P[i] = P[i+1] * G[i] per level, fetching gate matrices and driving an
// external multiplier only on misses; level 0 is the product presented downstream.
module sequence_product_cache
    import sequence_product_cache_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int IDX_BITS     = 4,
    parameter int HIT_CNT_BITS = 16
) (
    input logic                     clk,
    input logic                     reset,
    sequence_product_cache_if.slave bus
);

    state_e state_q, state_d;

    logic [IDX_BITS-1:0]     idx_q;
    logic [GATE_BITS-1:0]    gate_q;
    logic                    first_q;
    logic                    loadedVld_q;
    logic [GATE_BITS-1:0]    loadedGate_q;
    cmat_t                   loadedMtx_q;
    cmat_t                   prod_q;
    logic [HIT_CNT_BITS-1:0] hitCount_q;
    logic                    err_q, err_d;
    logic                    resultValid_q, resultValid_d;
    logic                    gtReq_q, gtReq_d;
    logic                    mulStart_q, mulStart_d;

    logic                    transfer, inRange, lastLevel, nextVld;
    logic                    reject, hit, gateLoaded;
    logic                    hitInc, tagWe, wrEn, flushCache, loadGate, capture;
    logic                    lkVld, lkFirst;
    logic [GATE_BITS-1:0]    lkGate;
    logic [DEPTH-1:0]        vld;
    cmat_t                   rdMtx, lvl0Mtx, wrMtx;

    sequence_product_cache_bank #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) bank (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flushCache),
        .lkIdx_i    (bus.seq_index),
        .tagWe_i    (tagWe),
        .tagGate_i  (bus.seq_gate),
        .tagFirst_i (bus.seq_first),
        .wrEn_i     (wrEn),
        .wrIdx_i    (idx_q),
        .wrMtx_i    (wrMtx),
        .rdIdx_i    (idx_q + IDX_BITS'(1)),
        .rdMtx_o    (rdMtx),
        .lvl0Mtx_o  (lvl0Mtx),
        .lkVld_o    (lkVld),
        .lkGate_o   (lkGate),
        .lkFirst_o  (lkFirst),
        .vld_o      (vld)
    );

    assign bus.seq_ready = (state_q == IDLE) && !bus.flush;
    assign transfer      = bus.seq_valid && bus.seq_ready;

    // A non-first gate needs a valid parent product one level up.
    always_comb begin
        inRange   = bus.seq_index < IDX_BITS'(DEPTH);
        lastLevel = bus.seq_index == IDX_BITS'(DEPTH - 1);
        nextVld   = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (IDX_BITS'(j) == bus.seq_index + IDX_BITS'(1)) begin
                nextVld = vld[j];
            end
        end
        reject     = !inRange || (!bus.seq_first && (lastLevel || !nextVld));
        hit        = lkVld && lkGate == bus.seq_gate && lkFirst == bus.seq_first;
        gateLoaded = loadedVld_q && loadedGate_q == bus.seq_gate;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (transfer && !reject && !hit) begin
                    if (gateLoaded) begin
                        state_d = bus.seq_first ? WRITE : MUL;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (bus.gt_done) begin
                    state_d = first_q ? WRITE : MUL;
                end
            end
            MUL: begin
                if (bus.mul_done) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d         = 1'b0;
        resultValid_d = 1'b0;
        gtReq_d       = 1'b0;
        mulStart_d    = 1'b0;
        hitInc        = 1'b0;
        tagWe         = 1'b0;
        wrEn          = 1'b0;
        flushCache    = 1'b0;
        loadGate      = 1'b0;
        capture       = 1'b0;
        wrMtx         = first_q ? loadedMtx_q : prod_q;
        unique case (state_q)
            IDLE: begin
                flushCache = bus.flush;
                if (transfer) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else if (hit) begin
                        hitInc        = 1'b1;
                        resultValid_d = (bus.seq_index == '0);
                    end else begin
                        tagWe      = 1'b1;
                        gtReq_d    = !gateLoaded;
                        mulStart_d = gateLoaded && !bus.seq_first;
                    end
                end
            end
            FETCH: begin
                if (bus.gt_done) begin
                    loadGate   = 1'b1;
                    mulStart_d = !first_q;
                end
            end
            MUL: begin
                capture = bus.mul_done;
            end
            WRITE: begin
                wrEn          = 1'b1;
                resultValid_d = (idx_q == '0);
            end
            default: ;
        endcase
    end

    // Pulses are registered so each response appears the cycle after its cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            loadedVld_q   <= 1'b0;
            hitCount_q    <= '0;
            err_q         <= 1'b0;
            resultValid_q <= 1'b0;
            gtReq_q       <= 1'b0;
            mulStart_q    <= 1'b0;
        end else begin
            err_q         <= err_d;
            resultValid_q <= resultValid_d;
            gtReq_q       <= gtReq_d;
            mulStart_q    <= mulStart_d;
            if (flushCache) begin
                loadedVld_q <= 1'b0;
            end else if (loadGate) begin
                loadedVld_q <= 1'b1;
            end
            if (hitInc && hitCount_q != '1) begin
                hitCount_q <= hitCount_q + HIT_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) begin
            idx_q   <= bus.seq_index;
            gate_q  <= bus.seq_gate;
            first_q <= bus.seq_first;
        end
        if (loadGate) begin
            loadedGate_q <= gate_q;
            loadedMtx_q  <= bus.gt_mtx;
        end
        if (capture) begin
            prod_q <= bus.mul_result;
        end
    end

    assign bus.err          = err_q;
    assign bus.result_valid = resultValid_q;
    assign bus.gt_req       = gtReq_q;
    assign bus.mul_start    = mulStart_q;
    assign bus.gt_gate      = gate_q;
    assign bus.hit_count    = hitCount_q;
    assign bus.result_mtx   = lvl0Mtx;
    assign bus.mul_a        = rdMtx;
    assign bus.mul_b        = loadedMtx_q;

endmodule

// File: tb/tb_sequence_product_cache.sv
// Scoreboarded bench: directed and random gate sequences against a per-level
// product model, with bench-side gate table and multiplier responders.
module tb_sequence_product_cache;
    import sequence_product_cache_pkg::*;

    localparam int DEPTH = 8, IDX_BITS = 4, HIT_CNT_BITS = 16, FRAC = 16;
    localparam int ONE = 65536, R = 46341;
    localparam int G_I = 0, G_H = 1, G_T = 2, G_S = 3, G_X = 4, G_Z = 5, G_Y = 6;

    typedef struct {
        bit    isErr;
        bit    timed;
        cmat_t mtx;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sequence_product_cache_if #(.IDX_BITS(IDX_BITS), .HIT_CNT_BITS(HIT_CNT_BITS)) bus();

    sequence_product_cache #(
        .DEPTH(DEPTH), .IDX_BITS(IDX_BITS), .HIT_CNT_BITS(HIT_CNT_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0, errors = 0, cyc = 0;
    int gtSeen = 0, mulSeen = 0, expGt = 0, expMul = 0, mHits = 0;
    bit mulAuto = 1'b1;
    exp_t sbq[$];

    cmat_t mMtx [DEPTH];
    int    mGate[DEPTH];
    bit    mFirst[DEPTH];
    bit    mVld [DEPTH];
    bit    mLoadVld = 1'b0;
    int    mLoadGate = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic cmat_t gateMatrix(input int id);
        int e[8];
        cmat_t m;
        case (id)
            G_H:     e = '{R, 0, R, 0, R, 0, -R, 0};
            G_T:     e = '{ONE, 0, 0, 0, 0, 0, R, R};
            G_S:     e = '{ONE, 0, 0, 0, 0, 0, 0, ONE};
            G_X:     e = '{0, 0, ONE, 0, ONE, 0, 0, 0};
            G_Z:     e = '{ONE, 0, 0, 0, 0, 0, -ONE, 0};
            G_Y:     e = '{0, 0, 0, -ONE, 0, ONE, 0, 0};
            default: e = '{ONE, 0, 0, 0, 0, 0, ONE, 0};
        endcase
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 2; p++)
                    m[r][c][p] = NUMERIC_BITS'(e[r*4 + c*2 + p]);
        return m;
    endfunction

    function automatic longint el(input cmat_t m, input int r, input int c, input int p);
        return longint'($signed(m[r][c][p]));
    endfunction

    // Complex matrix product a*b with fixed-point truncation of each accumulated element.
    function automatic cmat_t cmul(input cmat_t a, input cmat_t b);
        cmat_t m;
        longint re, im;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                re = 0;
                im = 0;
                for (int k = 0; k < 2; k++) begin
                    re += el(a, r, k, 0) * el(b, k, c, 0) - el(a, r, k, 1) * el(b, k, c, 1);
                    im += el(a, r, k, 0) * el(b, k, c, 1) + el(a, r, k, 1) * el(b, k, c, 0);
                end
                m[r][c][0] = NUMERIC_BITS'(re >>> FRAC);
                m[r][c][1] = NUMERIC_BITS'(im >>> FRAC);
            end
        return m;
    endfunction

    task automatic modelClear();
        for (int j = 0; j < DEPTH; j++) mVld[j] = 1'b0;
        mLoadVld = 1'b0;
    endtask

    task automatic modelStep(input int idx, input int gate, input bit first,
                             output bit push, output exp_t e);
        e = '{isErr: 1'b0, timed: 1'b0, mtx: '0, cyc: 0};
        push = 1'b0;
        if (idx >= DEPTH || (!first && (idx == DEPTH - 1 || !mVld[idx+1]))) begin
            push    = 1'b1;
            e.isErr = 1'b1;
            e.timed = 1'b1;
        end else if (mVld[idx] && mGate[idx] == gate && mFirst[idx] == first) begin
            if (mHits < 65535) mHits++;
            if (idx == 0) begin
                push    = 1'b1;
                e.timed = 1'b1;
                e.mtx   = mMtx[0];
            end
        end else begin
            mGate[idx]  = gate;
            mFirst[idx] = first;
            for (int j = 0; j <= idx; j++) mVld[j] = 1'b0;
            if (!(mLoadVld && mLoadGate == gate)) begin
                expGt++;
                mLoadVld  = 1'b1;
                mLoadGate = gate;
            end
            if (first) begin
                mMtx[idx] = gateMatrix(gate);
            end else begin
                expMul++;
                mMtx[idx] = cmul(mMtx[idx+1], gateMatrix(gate));
            end
            mVld[idx] = 1'b1;
            if (idx == 0) begin
                push  = 1'b1;
                e.mtx = mMtx[0];
            end
        end
    endtask

    task automatic checkOutput(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic applyStimulus(input int idx, input int gate, input bit first, input bit track);
        int   n;
        bit   push;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.seq_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyWait", bus.seq_ready, 1);
        if (!bus.seq_ready) return;
        bus.seq_valid = 1'b1;
        bus.seq_index = IDX_BITS'(idx);
        bus.seq_gate  = GATE_BITS'(gate);
        bus.seq_first = first;
        push = 1'b0;
        if (track) modelStep(idx, gate, first, push, e);
        @(posedge clk);
        #1;
        bus.seq_valid = 1'b0;
        if (push) begin
            e.cyc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !bus.seq_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drainPending", sbq.size(), 0);
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, ".hitCount"}, bus.hit_count, mHits);
        checkOutput({tag, ".gtReqs"}, gtSeen, expGt);
        checkOutput({tag, ".mulStarts"}, mulSeen, expMul);
    endtask

    task automatic doFlush();
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("readyDuringFlush", bus.seq_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        modelClear();
        #1;
        checkOutput("readyAfterFlush", bus.seq_ready, 1);
    endtask

    // Scoreboard monitor: every result_valid / err pulse consumes one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.gt_req) gtSeen++;
            if (bus.mul_start) mulSeen++;
            if (bus.result_valid || bus.err) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedResponse: result_valid=%0b err=%0b, required no response",
                             bus.result_valid, bus.err);
                end else begin
                    e = sbq.pop_front();
                    if (e.isErr && !(bus.err && !bus.result_valid)) begin
                        errors++;
                        $display("[TB] FAIL errPulse: result_valid=%0b err=%0b, required err only",
                                 bus.result_valid, bus.err);
                    end else if (!e.isErr && !(bus.result_valid && !bus.err && bus.result_mtx == e.mtx)) begin
                        errors++;
                        $display("[TB] FAIL resultMtx: rv=%0b err=%0b got %h required %h",
                                 bus.result_valid, bus.err, bus.result_mtx, e.mtx);
                    end
                    if (e.timed) checkOutput("responseLatency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        bus.gt_done = 1'b0;
        bus.gt_mtx  = '0;
        forever begin
            @(negedge clk);
            if (bus.gt_req && !reset) begin
                int g;
                g = int'(bus.gt_gate);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bus.gt_mtx  = gateMatrix(g);
                bus.gt_done = 1'b1;
                @(negedge clk);
                bus.gt_done = 1'b0;
            end
        end
    end

    initial begin
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_start && !reset && mulAuto) begin
                cmat_t a, b;
                a = bus.mul_a;
                b = bus.mul_b;
                repeat ($urandom_range(0, 4)) @(negedge clk);
                checkOutput("mulOperandsStable", (bus.mul_a == a && bus.mul_b == b) ? 1 : 0, 1);
                bus.mul_result = cmul(a, b);
                bus.mul_done   = 1'b1;
                @(negedge clk);
                bus.mul_done = 1'b0;
            end
        end
    end

    initial begin
        int n;
        bus.flush     = 1'b0;
        bus.seq_valid = 1'b0;
        bus.seq_index = '0;
        bus.seq_gate  = '0;
        bus.seq_first = 1'b0;
        modelClear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("resetReady", bus.seq_ready, 1);
        checkOutput("resetResultValid", bus.result_valid, 0);
        checkOutput("resetErr", bus.err, 0);
        checkOutput("resetHitCount", bus.hit_count, 0);
        checkOutput("resetGtReq", bus.gt_req, 0);

        applyStimulus(3, G_H, 1, 1);
        drain();
        checkCounts("firstGate");
        applyStimulus(2, G_T, 0, 1);
        applyStimulus(1, G_H, 0, 1);
        applyStimulus(0, G_X, 0, 1);
        drain();
        checkCounts("chain");

        for (int l = 3; l >= 0; l--) applyStimulus(l, (l == 3 || l == 1) ? G_H : (l == 2 ? G_T : G_X), l == 3, 1);
        drain();
        checkCounts("replay");

        applyStimulus(2, G_S, 0, 1);
        applyStimulus(1, G_H, 0, 1);
        applyStimulus(0, G_X, 0, 1);
        drain();
        checkCounts("changeLevel2");

        applyStimulus(DEPTH, G_H, 1, 1);
        applyStimulus(15, G_X, 0, 1);
        applyStimulus(DEPTH - 1, G_T, 0, 1);
        applyStimulus(5, G_H, 0, 1);
        applyStimulus(0, G_X, 0, 1);
        drain();
        checkCounts("rejects");

        for (int chain = 0; chain < 30; chain++) begin
            int s;
            s = $urandom_range(0, DEPTH - 1);
            applyStimulus(s, $urandom_range(1, 3), 1, 1);
            for (int l = s - 1; l >= 0; l--) begin
                if ($urandom_range(0, 7) == 0)
                    applyStimulus($urandom_range(0, 15), $urandom_range(0, 6), $urandom_range(0, 1), 1);
                else
                    applyStimulus(l, $urandom_range(1, 3), 0, 1);
            end
        end
        drain();
        checkCounts("random");

        // Reset while the multiplier is busy, then a stray done that must be ignored.
        doFlush();
        applyStimulus(1, G_H, 1, 1);
        drain();
        mulAuto = 1'b0;
        n = mulSeen;
        applyStimulus(0, G_Z, 0, 0);
        begin
            int w;
            w = 0;
            while (mulSeen == n && w < 100) begin
                @(negedge clk);
                w++;
            end
        end
        checkOutput("reachedMul", mulSeen, n + 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelClear();
        mHits = 0;
        gtSeen = 0; mulSeen = 0; expGt = 0; expMul = 0;
        repeat (3) @(negedge clk);
        bus.mul_result = cmul(gateMatrix(G_Y), gateMatrix(G_T));
        bus.mul_done   = 1'b1;
        @(negedge clk);
        bus.mul_done = 1'b0;
        repeat (4) @(negedge clk);
        mulAuto = 1'b1;
        checkOutput("postResetReady", bus.seq_ready, 1);
        checkOutput("postResetHitCount", bus.hit_count, 0);
        applyStimulus(0, G_Z, 0, 1);
        applyStimulus(1, G_H, 1, 1);
        applyStimulus(0, G_Z, 0, 1);
        drain();
        checkCounts("afterReset");

        doFlush();
        applyStimulus(0, G_Z, 0, 1);
        applyStimulus(1, G_H, 1, 1);
        applyStimulus(0, G_X, 0, 1);
        drain();
        checkCounts("afterFlush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
